// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-strobed write, combinational read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Write only the byte lanes whose strobe is set.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed response latency.
// Optional feature: define DMEM_ERR_EN to flag addresses beyond the array
// (store suppressed, load returns zero, rsp_err_o raised).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               enter_resp;

    logic [ADDR_W-1:0]  req_idx;
    logic               req_err;
    logic               accept;
    logic               mem_we;

    // Request fields held while the load is in flight. The store itself
    // commits on the accept edge, so its data and strobes need no holding.
    logic [ADDR_W-1:0]  idx_p0;
    logic               write_p0;

    logic [ADDR_W-1:0]  cur_idx;
    logic               cur_write;
    logic               cur_err;
    logic [WORD_W-1:0]  mem_rdata;
    logic [WORD_W-1:0]  rsp_rdata_q;
    logic               unused_addr;

    assign req_idx = req_addr_i[ADDR_W+1:2];
    assign accept  = (state_q == IDLE) && req_valid_i;
    assign mem_we  = accept && req_write_i && !req_err;

`ifdef DMEM_ERR_EN
    logic err_p0;
    logic rsp_err_q;

    assign req_err     = |req_addr_i[31:ADDR_W+2];
    assign cur_err     = (state_q == IDLE) ? req_err : err_p0;
    assign unused_addr = ^req_addr_i[1:0];
    assign rsp_err_o   = rsp_err_q;

    // Error flag for the pending request, then for the presented response.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_p0    <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                err_p0 <= req_err;
            end
            if (enter_resp) begin
                rsp_err_q <= cur_err;
            end else if (state_q == RESP && rsp_ready_i) begin
                rsp_err_q <= 1'b0;
            end
        end
    end
`else
    assign req_err     = 1'b0;
    assign cur_err     = 1'b0;
    assign unused_addr = ^{req_addr_i[31:ADDR_W+2], req_addr_i[1:0]};
    assign rsp_err_o   = 1'b0;
`endif

    // With LATENCY==1 RESP is entered straight from IDLE, so the load must
    // read using the live request rather than the held copy.
    assign cur_idx   = (state_q == IDLE) ? req_idx     : idx_p0;
    assign cur_write = (state_q == IDLE) ? req_write_i : write_p0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .waddr (req_idx),
        .wdata (req_wdata_i),
        .wstrb (req_wstrb_i),
        .raddr (cur_idx),
        .rdata (mem_rdata)
    );

    // Next-state and latency countdown.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cnt_d = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold the accepted request's word index and direction.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_p0   <= req_idx;
            write_p0 <= req_write_i;
        end
    end

    // Capture load data on the edge entering RESP; stores and errors return zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_rdata_q <= '0;
        end else if (enter_resp) begin
            rsp_rdata_q <= (cur_write || cur_err) ? '0 : mem_rdata;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=3). Build with or without
// DMEM_ERR_EN; the out-of-range expectations follow the macro.
module tb_dmem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb_q [$];   // {err, rdata}

    dmem_responder #(
        .DEPTH_WORDS (256),
        .ADDR_W      (8),
        .LATENCY     (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every response at the handshake against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d with nothing expected",
                         rsp_rdata_o, rsp_err_o);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, e[31:0]);
                check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e[32]});
            end
        end
    end

    // Issue one request (called 1ns after a rising edge); returns 1ns after the accept edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit expect_rsp);
        int guard = 0;
        while (!req_ready_o && guard < 50) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!req_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: got ready 0 expected 1 within 50 cycles");
        end
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_wstrb_i = strb;
        req_valid_i = 1'b1;
        if (expect_rsp) sb_q.push_back({exp_err, exp_rdata});
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check("drain_pending", sb_q.size(), 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 0);
        check("rst_req_ready", {31'd0, req_ready_o}, 1);
        check("rst_rdata", rsp_rdata_o, 32'h0);
        check("rst_err", {31'd0, rsp_err_o}, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Store then load
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        // Byte lanes ignored in the address
        issue(1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        // Byte strobes, then an all-zero strobe that must leave memory alone
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b1);
        drain();

        // Latency: accept edge t, response first visible after t+3
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1);
        check("lat_t0_ready", {31'd0, req_ready_o}, 0);
        check("lat_t0_valid", {31'd0, rsp_valid_o}, 0);
        @(posedge clk_i); #1;
        check("lat_t1_ready", {31'd0, req_ready_o}, 0);
        check("lat_t1_valid", {31'd0, rsp_valid_o}, 0);
        @(posedge clk_i); #1;
        check("lat_t2_valid", {31'd0, rsp_valid_o}, 0);
        @(posedge clk_i); #1;
        check("lat_t3_valid", {31'd0, rsp_valid_o}, 1);
        check("lat_t3_ready", {31'd0, req_ready_o}, 0);
        drain();

        // Backpressure: response held, new requests refused
        rsp_ready_i = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        begin
            int guard = 0;
            while (!rsp_valid_o && guard < 20) begin
                @(posedge clk_i); #1;
                guard++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            req_write_i = 1'b1;
            req_addr_i  = 32'h10;
            req_wdata_i = 32'h0;
            req_wstrb_i = 4'hF;
            req_valid_i = (i % 2 == 0);
            check("bp_valid", {31'd0, rsp_valid_o}, 1);
            check("bp_rdata", rsp_rdata_o, 32'hDEADBEEF);
            check("bp_req_ready", {31'd0, req_ready_o}, 0);
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        drain();
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        // Range handling
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h4, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
`ifdef DMEM_ERR_EN
        issue(1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        drain();
        issue(1'b1, 32'h404, 32'h12345678, 4'hF, 32'h0, 1'b1, 1'b1);
        drain();
        issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h0BADC0DE, 1'b0, 1'b1);
        drain();
`else
        issue(1'b0, 32'h400, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();
        issue(1'b1, 32'h404, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1);
        drain();
`endif

        // Asynchronous reset while waiting: request is dropped
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_valid", {31'd0, rsp_valid_o}, 0);
        check("arst_req_ready", {31'd0, req_ready_o}, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk_i); #1;
                if (rsp_valid_o) seen = 1'b1;
            end
            check("arst_no_rsp", {31'd0, seen}, 0);
        end
        check("arst_ready_after", {31'd0, req_ready_o}, 1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
